idex_pipeline_reg: RTL and testbench

IDEX_PIPELINE_REG -- requirements
Module: idex_pipeline_reg

---
 rtl/idex_pipeline_reg.sv | 146 ++++++++++++++
 tb/tb_idex_pipeline_reg.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/idex_pipeline_reg.sv
// ID/EX pipeline register with load-use bubble, branch flush and downstream hold.
// Also tracks saturating counts of inserted bubbles and held cycles.
module idex_pipeline_reg #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned REG_ADDR_WIDTH = 4,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      controls_clear,
  input  logic                      flush,
  input  logic                      hold,
  input  logic                      id_valid,
  input  logic                      id_regwrite,
  input  logic                      id_memread,
  input  logic                      id_memwrite,
  input  logic                      id_memtoreg,
  input  logic                      id_alusrc,
  input  logic                      id_branch,
  input  logic [3:0]                id_aluop,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic [DATA_WIDTH-1:0]     id_rs_data,
  input  logic [DATA_WIDTH-1:0]     id_rt_data,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic [DATA_WIDTH-1:0]     id_pc,
  output logic                      idex_valid,
  output logic                      idex_regwrite,
  output logic                      idex_memread,
  output logic                      idex_memwrite,
  output logic                      idex_memtoreg,
  output logic                      idex_alusrc,
  output logic                      idex_branch,
  output logic [3:0]                idex_aluop,
  output logic [REG_ADDR_WIDTH-1:0] idex_rs,
  output logic [REG_ADDR_WIDTH-1:0] idex_rt,
  output logic [REG_ADDR_WIDTH-1:0] idex_rd,
  output logic [DATA_WIDTH-1:0]     idex_rs_data,
  output logic [DATA_WIDTH-1:0]     idex_rt_data,
  output logic [DATA_WIDTH-1:0]     idex_imm,
  output logic [DATA_WIDTH-1:0]     idex_pc,
  output logic [CNT_WIDTH-1:0]      bubble_count,
  output logic [CNT_WIDTH-1:0]      hold_count
);

  localparam int unsigned ALUOP_WIDTH = 4;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {
    EMPTY = 1'b0,
    VALID = 1'b1
  } state_t;

  typedef struct packed {
    logic                      regwrite;
    logic                      memread;
    logic                      memwrite;
    logic                      memtoreg;
    logic                      alusrc;
    logic                      branch;
    logic [ALUOP_WIDTH-1:0]    aluop;
    logic [REG_ADDR_WIDTH-1:0] rs;
    logic [REG_ADDR_WIDTH-1:0] rt;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     rs_data;
    logic [DATA_WIDTH-1:0]     rt_data;
    logic [DATA_WIDTH-1:0]     imm;
    logic [DATA_WIDTH-1:0]     pc;
  } payload_t;

  state_t   state_q, state_d;
  payload_t payload_q, payload_d, id_payload;
  logic     bubble_inc, hold_inc;
  logic [CNT_WIDTH-1:0] bubble_count_q, hold_count_q;

  assign id_payload = '{
    regwrite: id_regwrite, memread: id_memread, memwrite: id_memwrite,
    memtoreg: id_memtoreg, alusrc: id_alusrc, branch: id_branch,
    aluop: id_aluop, rs: id_rs, rt: id_rt, rd: id_rd,
    rs_data: id_rs_data, rt_data: id_rt_data, imm: id_imm, pc: id_pc
  };

  // Action select: hold > flush/clear (bubble) > load; reset is applied in the register.
  always_comb begin
    state_d    = state_q;
    payload_d  = payload_q;
    bubble_inc = 1'b0;
    hold_inc   = 1'b0;
    if (hold) begin
      hold_inc = 1'b1;
    end else if (flush || controls_clear) begin
      state_d    = EMPTY;
      payload_d  = '0;
      bubble_inc = 1'b1;
    end else begin
      state_d   = id_valid ? VALID : EMPTY;
      payload_d = id_payload;
      if (!id_valid) begin
        payload_d.regwrite = 1'b0;
        payload_d.memread  = 1'b0;
        payload_d.memwrite = 1'b0;
        payload_d.memtoreg = 1'b0;
        payload_d.alusrc   = 1'b0;
        payload_d.branch   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= EMPTY;
      payload_q      <= '0;
      bubble_count_q <= '0;
      hold_count_q   <= '0;
    end else begin
      state_q   <= state_d;
      payload_q <= payload_d;
      if (bubble_inc && (bubble_count_q != CNT_MAX)) begin
        bubble_count_q <= bubble_count_q + CNT_WIDTH'(1);
      end
      if (hold_inc && (hold_count_q != CNT_MAX)) begin
        hold_count_q <= hold_count_q + CNT_WIDTH'(1);
      end
    end
  end

  assign idex_valid    = (state_q == VALID);
  assign idex_regwrite = payload_q.regwrite;
  assign idex_memread  = payload_q.memread;
  assign idex_memwrite = payload_q.memwrite;
  assign idex_memtoreg = payload_q.memtoreg;
  assign idex_alusrc   = payload_q.alusrc;
  assign idex_branch   = payload_q.branch;
  assign idex_aluop    = payload_q.aluop;
  assign idex_rs       = payload_q.rs;
  assign idex_rt       = payload_q.rt;
  assign idex_rd       = payload_q.rd;
  assign idex_rs_data  = payload_q.rs_data;
  assign idex_rt_data  = payload_q.rt_data;
  assign idex_imm      = payload_q.imm;
  assign idex_pc       = payload_q.pc;
  assign bubble_count  = bubble_count_q;
  assign hold_count    = hold_count_q;

endmodule

// File: tb/tb_idex_pipeline_reg.sv
// Directed, table-driven bench for idex_pipeline_reg (counters built 4 bits wide).
module tb_idex_pipeline_reg;

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 4;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, controls_clear, flush, hold, id_valid;
  logic id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_branch;
  logic [3:0] id_aluop;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm, id_pc;
  logic idex_valid, idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg, idex_alusrc, idex_branch;
  logic [3:0] idex_aluop;
  logic [RW-1:0] idex_rs, idex_rt, idex_rd;
  logic [DW-1:0] idex_rs_data, idex_rt_data, idex_imm, idex_pc;
  logic [CW-1:0] bubble_count, hold_count;

  idex_pipeline_reg #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .controls_clear(controls_clear), .flush(flush), .hold(hold),
    .id_valid(id_valid), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc),
    .id_branch(id_branch), .id_aluop(id_aluop), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pc(id_pc),
    .idex_valid(idex_valid), .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
    .idex_memwrite(idex_memwrite), .idex_memtoreg(idex_memtoreg), .idex_alusrc(idex_alusrc),
    .idex_branch(idex_branch), .idex_aluop(idex_aluop), .idex_rs(idex_rs), .idex_rt(idex_rt),
    .idex_rd(idex_rd), .idex_rs_data(idex_rs_data), .idex_rt_data(idex_rt_data),
    .idex_imm(idex_imm), .idex_pc(idex_pc), .bubble_count(bubble_count), .hold_count(hold_count)
  );

  // Field bundle; ctl = {regwrite, memread, memwrite, memtoreg, alusrc, branch}
  typedef struct packed {
    logic          v;
    logic [5:0]    ctl;
    logic [3:0]    aluop;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic [DW-1:0] rsd;
    logic [DW-1:0] rtd;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc;
  } io_t;

  typedef struct {
    string         name;
    logic          rst, clr, fl, hd;
    io_t           in;
    io_t           exp;
    logic [CW-1:0] bc, hc;
  } vec_t;

  io_t act;
  assign act = '{v: idex_valid,
                 ctl: {idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg, idex_alusrc, idex_branch},
                 aluop: idex_aluop, rs: idex_rs, rt: idex_rt, rd: idex_rd,
                 rsd: idex_rs_data, rtd: idex_rt_data, imm: idex_imm, pc: idex_pc};

  int n_tests = 0;
  int n_fail  = 0;

  function automatic io_t mk(input logic v, input logic [5:0] c, input logic [3:0] a,
                             input logic [RW-1:0] rs, input logic [RW-1:0] rt, input logic [RW-1:0] rd,
                             input logic [DW-1:0] rsd, input logic [DW-1:0] rtd,
                             input logic [DW-1:0] imm, input logic [DW-1:0] pc);
    mk = '{v: v, ctl: c, aluop: a, rs: rs, rt: rt, rd: rd, rsd: rsd, rtd: rtd, imm: imm, pc: pc};
  endfunction

  task automatic drive(input logic rst, input logic clr, input logic fl, input logic hd, input io_t in);
    @(negedge clk);
    reset = rst; controls_clear = clr; flush = fl; hold = hd;
    id_valid = in.v;
    {id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_branch} = in.ctl;
    id_aluop = in.aluop; id_rs = in.rs; id_rt = in.rt; id_rd = in.rd;
    id_rs_data = in.rsd; id_rt_data = in.rtd; id_imm = in.imm; id_pc = in.pc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_io(input string nm, input io_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s fields: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_cnt(input string nm, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  vec_t vecs[14];
  io_t  a_i, b_i, h_i, n_i, n_e, c_i, e_i, l_i, z;

  initial begin
    reset = 1'b1; controls_clear = 1'b0; flush = 1'b0; hold = 1'b0; id_valid = 1'b0;
    {id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_branch} = '0;
    id_aluop = '0; id_rs = '0; id_rt = '0; id_rd = '0;
    id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_pc = '0;

    z   = '0;
    a_i = mk(1'b1, 6'b010000, 4'h5, 4'h1, 4'h3, 4'h2, 16'hBEEF, 16'h1234, 16'hFFFE, 16'h0040);
    l_i = mk(1'b1, 6'b100000, 4'h1, 4'h2, 4'h7, 4'h3, 16'h1111, 16'h2222, 16'h3333, 16'h0048);
    b_i = mk(1'b1, 6'b101011, 4'hA, 4'h6, 4'h5, 4'h7, 16'hCAFE, 16'h0F0F, 16'h0010, 16'h0044);
    h_i = mk(1'b1, 6'b111111, 4'hF, 4'hF, 4'hF, 4'hF, 16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD);
    n_i = mk(1'b0, 6'b111111, 4'h3, 4'h8, 4'h9, 4'hA, 16'h5555, 16'h6666, 16'h7777, 16'h0050);
    n_e = mk(1'b0, 6'b000000, 4'h3, 4'h8, 4'h9, 4'hA, 16'h5555, 16'h6666, 16'h7777, 16'h0050);
    c_i = mk(1'b1, 6'b000001, 4'h2, 4'h3, 4'h2, 4'h1, 16'h0001, 16'h0002, 16'h0003, 16'h0060);
    e_i = mk(1'b1, 6'b010000, 4'h4, 4'h0, 4'h4, 4'h5, 16'hABCD, 16'h0000, 16'h0008, 16'h0070);

    //            name              rst   clr   fl    hd    in    exp  bc    hc
    vecs[0]  = '{"reset",          1'b1, 1'b0, 1'b0, 1'b0, a_i,  z,   4'd0, 4'd0};
    vecs[1]  = '{"first_load",     1'b0, 1'b0, 1'b0, 1'b0, a_i,  a_i, 4'd0, 4'd0};
    vecs[2]  = '{"load_use",       1'b0, 1'b1, 1'b0, 1'b0, l_i,  z,   4'd1, 4'd0};
    vecs[3]  = '{"load_b",         1'b0, 1'b0, 1'b0, 1'b0, b_i,  b_i, 4'd1, 4'd0};
    vecs[4]  = '{"hold1",          1'b0, 1'b1, 1'b1, 1'b1, h_i,  b_i, 4'd1, 4'd1};
    vecs[5]  = '{"hold2",          1'b0, 1'b1, 1'b1, 1'b1, h_i,  b_i, 4'd1, 4'd2};
    vecs[6]  = '{"hold3",          1'b0, 1'b1, 1'b1, 1'b1, h_i,  b_i, 4'd1, 4'd3};
    vecs[7]  = '{"flush_and_clr",  1'b0, 1'b1, 1'b1, 1'b0, a_i,  z,   4'd2, 4'd3};
    vecs[8]  = '{"load_invalid",   1'b0, 1'b0, 1'b0, 1'b0, n_i,  n_e, 4'd2, 4'd3};
    vecs[9]  = '{"flush_only",     1'b0, 1'b0, 1'b1, 1'b0, c_i,  z,   4'd3, 4'd3};
    vecs[10] = '{"load_c",         1'b0, 1'b0, 1'b0, 1'b0, c_i,  c_i, 4'd3, 4'd3};
    vecs[11] = '{"reset_mid_hold", 1'b1, 1'b0, 1'b0, 1'b1, a_i,  z,   4'd0, 4'd0};
    vecs[12] = '{"load_after_rst", 1'b0, 1'b0, 1'b0, 1'b0, e_i,  e_i, 4'd0, 4'd0};
    vecs[13] = '{"reset_again",    1'b1, 1'b1, 1'b1, 1'b0, h_i,  z,   4'd0, 4'd0};

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].clr, vecs[i].fl, vecs[i].hd, vecs[i].in);
      chk_io(vecs[i].name, vecs[i].exp);
      chk_cnt({vecs[i].name, " bubble_count"}, bubble_count, vecs[i].bc);
      chk_cnt({vecs[i].name, " hold_count"}, hold_count, vecs[i].hc);
    end

    // 20 back-to-back bubbles: the 4-bit counter must stop at 15
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, a_i);
      chk_cnt($sformatf("bubble_sat%0d", i), bubble_count, (i < 15) ? CW'(i + 1) : 4'd15);
    end
    chk_io("bubble_sat fields", z);

    // 17 held cycles after a load: hold_count stops at 15, bubble_count stays at 15
    drive(1'b0, 1'b0, 1'b0, 1'b0, b_i);
    chk_io("load_before_hold_sat", b_i);
    for (int i = 0; i < 17; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, h_i);
      chk_cnt($sformatf("hold_sat%0d", i), hold_count, (i < 15) ? CW'(i + 1) : 4'd15);
    end
    chk_cnt("hold_sat bubble_count", bubble_count, 4'd15);
    chk_io("hold_sat fields", b_i);

    // Reset while frozen clears both saturated counters
    drive(1'b1, 1'b0, 1'b0, 1'b1, h_i);
    chk_io("final_reset fields", z);
    chk_cnt("final_reset bubble_count", bubble_count, 4'd0);
    chk_cnt("final_reset hold_count", hold_count, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
